// File: rtl/divsqrt_iter_ctrl.sv
// -----------------------------------------------------------------------------
// divsqrt_iter_ctrl
//
// Issue and iteration controller for a shared iterative divide/square-root
// datapath. Several sources (index 0 = FP div/sqrt, index 1 = integer divide)
// compete for the unit. A fixed-priority arbiter picks the lowest-index
// requester, the winner's iteration count is loaded into a step counter, and
// the controller walks IDLE -> BUSY -> DONE -> IDLE. Operations flagged as
// special cases skip BUSY entirely. A zero residual can optionally end the
// iteration early.
//
// Ports
//   clk           in   clock; all state changes on the rising edge
//   reset         in   asynchronous, active-high reset
//   StartE        in   [NSRC]         per-source start request
//   SpecialCaseE  in   [NSRC]         per-source "no iteration needed" flag
//   CyclesE       in   [NSRC*DURLEN]  per-source iteration count, packed
//                                     source i at [i*DURLEN +: DURLEN]
//   WZeroE        in   residual is zero this cycle
//   StallM        in   memory-stage stall (holds DONE, blocks accept)
//   FlushE        in   execute-stage flush (kills operation in flight)
//   IFDivStartE   out  a start is accepted this cycle
//   GrantE        out  [NSRC] one-hot accepted source, zero when no accept
//   FDivBusyE     out  unit occupied (BUSY, or accepting this cycle)
//   FDivDoneE     out  result ready (state DONE)
//   SpecialCaseM  out  special-case flag of the accepted operation
//   SrcM          out  [NSRC] one-hot owner of the accepted operation
//   StepE         out  [DURLEN] step counter (iterations remaining)
//   EarlyTermM    out  last operation finished on a zero residual
// -----------------------------------------------------------------------------
module divsqrt_iter_ctrl #(
  parameter int DURLEN     = 6,
  parameter int NSRC       = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC-1:0]          StartE,
  input  logic [NSRC-1:0]          SpecialCaseE,
  input  logic [NSRC*DURLEN-1:0]   CyclesE,
  input  logic                     WZeroE,
  input  logic                     StallM,
  input  logic                     FlushE,
  output logic                     IFDivStartE,
  output logic [NSRC-1:0]          GrantE,
  output logic                     FDivBusyE,
  output logic                     FDivDoneE,
  output logic                     SpecialCaseM,
  output logic [NSRC-1:0]          SrcM,
  output logic [DURLEN-1:0]        StepE,
  output logic                     EarlyTermM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DURLEN-1:0]   step_reg, step_next;
  logic                spec_reg, spec_next;
  logic [NSRC-1:0]     src_reg, src_next;
  logic                early_reg, early_next;

  // ---------------------------------------------------------------------------
  // Fixed-priority arbiter: a source wins only if no lower index is requesting.
  // higher_pending[i] is the OR of all requests below index i.
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0]     higher_pending;
  logic [NSRC-1:0]     grant_raw;
  logic [DURLEN-1:0]   cycles_masked [NSRC];

  assign higher_pending[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NSRC; gi++) begin : g_prefix
      assign higher_pending[gi] = higher_pending[gi-1] | StartE[gi-1];
    end
  endgenerate

  assign grant_raw = StartE & ~higher_pending;

  // One-hot AND-OR select of the winner's iteration count.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_cyc_sel
      assign cycles_masked[gi] = grant_raw[gi] ? CyclesE[gi*DURLEN +: DURLEN]
                                               : '0;
    end
  endgenerate

  logic [DURLEN-1:0]   win_cycles;
  logic                win_special;

  always_comb begin
    win_cycles = '0;
    for (int i = 0; i < NSRC; i++) begin
      win_cycles = win_cycles | cycles_masked[i];
    end
  end

  assign win_special = |(grant_raw & SpecialCaseE);

  // ---------------------------------------------------------------------------
  // Accept. Gated by reset so nothing looks accepted while the unit is held
  // in reset even if a source is requesting.
  // ---------------------------------------------------------------------------
  logic accept;

  assign accept = (|StartE) && (state_reg == IDLE) && !StallM && !FlushE
                  && !reset;

  // ---------------------------------------------------------------------------
  // Iteration bookkeeping.
  // The counter and the state advance on the same edge: the last BUSY cycle is
  // the one whose decrement brings step down to 1, so DONE is entered showing
  // step==1 and the result is ready CyclesE cycles after the accept. A count of
  // 1 still spends one cycle in BUSY and decrements to 0.
  // ---------------------------------------------------------------------------
  logic [DURLEN-1:0] step_dec;
  logic              count_done;
  logic              zero_exit;

  assign step_dec   = (step_reg == '0) ? '0 : step_reg - DURLEN'(1);
  assign count_done = (step_reg <= DURLEN'(2));
  // Early exit only counts as "early" when the count was not finishing anyway.
  assign zero_exit  = (EARLY_TERM != 0) && WZeroE && !count_done;

  // ---------------------------------------------------------------------------
  // Next-state / latched-field logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    spec_next  = spec_reg;
    src_next   = src_reg;
    early_next = early_reg;

    if (FlushE) begin
      // Flush kills the operation; latched fields and the counter keep their
      // values so downstream can still inspect what was killed.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            spec_next  = win_special;
            src_next   = grant_raw;
            early_next = 1'b0;
            step_next  = win_cycles;
            if (win_special || (win_cycles == '0)) begin
              state_next = DONE;
            end else begin
              state_next = BUSY;
            end
          end
        end

        BUSY: begin
          step_next = step_dec;
          if (count_done) begin
            state_next = DONE;
          end else if (zero_exit) begin
            state_next = DONE;
            early_next = 1'b1;
          end
        end

        DONE: begin
          // A request seen during the exit cycle is not taken; it is accepted
          // in the following IDLE cycle if the source keeps asking.
          if (!StallM) begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      spec_reg  <= 1'b0;
      src_reg   <= '0;
      early_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      spec_reg  <= spec_next;
      src_reg   <= src_next;
      early_reg <= early_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign IFDivStartE  = accept;
  assign GrantE       = accept ? grant_raw : '0;
  assign FDivBusyE    = (state_reg == BUSY) || accept;
  assign FDivDoneE    = (state_reg == DONE);
  assign SpecialCaseM = spec_reg;
  assign SrcM         = src_reg;
  assign StepE        = step_reg;
  assign EarlyTermM   = early_reg;

endmodule

// File: doc/divsqrt_iter_ctrl.md
DIVSQRT_ITER_CTRL -- requirements
Module: divsqrt_iter_ctrl

Interface
REQ-001 Parameter DURLEN, default 6: width of the iteration-count and step counter.
REQ-002 Parameter NSRC, default 2: number of requesting sources; index 0 is FP div/sqrt, index 1 is integer divide.
REQ-003 Parameter EARLY_TERM, default 1: 1 enables early termination on zero residual.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 StartE  in  NSRC  per-source start request.
REQ-007 SpecialCaseE  in  NSRC  per-source special case; the operation needs no iteration.
REQ-008 CyclesE  in  NSRC*DURLEN  per-source iteration count; source i occupies bits [i*DURLEN +: DURLEN].
REQ-009 WZeroE  in  1  residual is zero this cycle.
REQ-010 StallM  in  1  Memory-stage stall.
REQ-011 FlushE  in  1  Execute-stage flush; kills the operation in flight.
REQ-012 IFDivStartE  out  1  a start is accepted this cycle.
REQ-013 GrantE  out  NSRC  one-hot accepted source; all zero when IFDivStartE=0.
REQ-014 FDivBusyE  out  1  unit occupied.
REQ-015 FDivDoneE  out  1  result is ready.
REQ-016 SpecialCaseM  out  1  latched special case of the accepted operation.
REQ-017 SrcM  out  NSRC  latched one-hot owner of the accepted operation.
REQ-018 StepE  out  DURLEN  iterations remaining.
REQ-019 EarlyTermM  out  1  the last operation ended through zero-residual termination.

Function
REQ-020 States SHALL be IDLE, BUSY and DONE, encoded in 2 bits.
REQ-021 Arbitration SHALL be fixed priority; the lowest-index asserted StartE wins.
REQ-022 IFDivStartE SHALL be (|StartE) & state==IDLE & ~StallM & ~FlushE.
REQ-023 Requests that lose arbitration SHALL be ignored (not queued); sources SHALL re-request.
REQ-024 On accept, SpecialCaseM SHALL capture SpecialCaseE of the winner and SrcM SHALL capture GrantE.
REQ-025 On accept, EarlyTermM SHALL clear to 0.
REQ-026 On accept, step SHALL load the winner's CyclesE.
REQ-027 On accept, the next state SHALL be DONE if the winner's special case is set or its CyclesE==0; otherwise BUSY.
REQ-028 In BUSY, the step counter SHALL decrement by 1 each cycle and saturate at 0 (no wrap).
REQ-029 BUSY SHALL go to DONE when step==1.
REQ-030 When EARLY_TERM=1, BUSY SHALL also go to DONE when WZeroE=1; with EARLY_TERM=0, WZeroE SHALL be ignored.
REQ-031 EarlyTermM SHALL set when the BUSY-to-DONE exit is caused by WZeroE while step!=1.
REQ-032 DONE SHALL go to IDLE when StallM=0 and SHALL hold DONE while StallM=1.
REQ-033 FDivDoneE SHALL be state==DONE.
REQ-034 FDivBusyE SHALL be state==BUSY | IFDivStartE.
REQ-035 StepE SHALL expose the step register directly.
REQ-036 FlushE SHALL force IDLE next cycle from any state, overriding accept and every transition; latched outputs SHALL hold their values.
REQ-037 The minimum latency SHALL be: accept in cycle N, FDivDoneE in cycle N+1 for a special case, N+CyclesE for a normal operation.
REQ-038 No new start SHALL be accepted in the same cycle DONE exits; the earliest next accept is the following IDLE cycle.

Reset
REQ-039 Asynchronous reset SHALL immediately force IDLE with step=0, SpecialCaseM=0, SrcM=0 and EarlyTermM=0, including mid-operation.
REQ-040 During reset, IFDivStartE, GrantE, FDivBusyE and FDivDoneE SHALL be 0.
REQ-041 The first accept SHALL be possible on the first clock edge after reset deasserts.

Verification
REQ-042 StartE=01, CyclesE[0]=5, no special case -> IFDivStartE=1 at cycle 0, FDivBusyE=1 for cycles 0-4, StepE 5,4,3,2,1, FDivDoneE=1 at cycle 5, IDLE at cycle 6.
REQ-043 StartE=11 -> GrantE=01, SrcM=01; source 1 is ignored; StartE=10 after return to IDLE -> GrantE=10.
REQ-044 Special case on source 1 with CyclesE=20 -> FDivDoneE=1 the next cycle, SpecialCaseM=1, never BUSY.
REQ-045 CyclesE=10, WZeroE pulsed at the 3rd BUSY cycle -> DONE next cycle, EarlyTermM=1; same stimulus with EARLY_TERM=0 -> full 10 cycles, EarlyTermM=0.
REQ-046 FlushE mid-BUSY -> IDLE next cycle, FDivDoneE never asserts; StallM held 3 cycles in DONE -> FDivDoneE held 4 cycles total.
REQ-047 Reset asserted between clock edges mid-BUSY -> outputs go to reset values before the next clk edge.
